// File: rtl/soc_bus_pkg.sv
// soc_bus_pkg: shared M65C02 bus encodings for IO_Op and MC microcycle states
package soc_bus_pkg;
  typedef enum logic [1:0] {
    IO_OP_NONE  = 2'b00,
    IO_OP_WRITE = 2'b01,
    IO_OP_READ  = 2'b10,
    IO_OP_FETCH = 2'b11
  } io_op_e;
  localparam logic [2:0] MC_C1 = 3'd6;
  localparam logic [2:0] MC_C2 = 3'd7;
  localparam logic [2:0] MC_C3 = 3'd5;
  localparam logic [2:0] MC_C4 = 3'd4;
endpackage

// File: rtl/dma_req_fifo.sv
// dma_req_fifo: in-order request queue, no push when full even while popping
module dma_req_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full  = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign dout  = mem_q[rd_q];
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    rd_d    = rd_q + AW'(do_pop);
    wr_d    = wr_q + AW'(do_push);
    cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din;
endmodule

// File: rtl/ram_dma_arbiter.sv
// ram_dma_arbiter: steals RAM slots the CPU provably leaves idle for a queued DMA requester
module ram_dma_arbiter
  import soc_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            cpu_io_op,
  input  logic [2:0]            cpu_mc,
  input  logic                  cpu_ram_cs,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic                  dma_req_valid,
  output logic                  dma_req_ready,
  input  logic                  dma_we,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic                  dma_rvalid,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic                  dma_busy,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);
  localparam int EW = 1 + ADDR_WIDTH + DATA_WIDTH;
  logic [EW-1:0] head;
  logic head_we, full, empty, cpu_claim, dma_slot;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_wdata;
  logic claim_q, claim_d, rd_pend_q, rd_pend_d, rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  dma_req_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (dma_req_valid),
    .pop   (dma_slot),
    .din   ({dma_we, dma_addr, dma_wdata}),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );
  assign {head_we, head_addr, head_wdata} = head;
  assign dma_req_ready = !full;
  assign dma_busy      = !empty || rd_pend_q;
  assign dma_rvalid    = rvalid_q;
  assign dma_rdata     = rdata_q;
  always_comb begin
    cpu_claim = cpu_ram_cs && cpu_io_op != IO_OP_NONE;
    dma_slot  = !empty && (cpu_mc == MC_C4 || (cpu_mc == MC_C1 && !cpu_claim) ||
                           ((cpu_mc == MC_C2 || cpu_mc == MC_C3) && !claim_q));
    claim_d   = cpu_mc == MC_C1 ? cpu_claim : claim_q;
    rd_pend_d = dma_slot && !head_we;
    rvalid_d  = rd_pend_q;
    rdata_d   = rd_pend_q ? ram_rdata : rdata_q;
    ram_addr  = dma_slot ? head_addr : cpu_addr;
    ram_wdata = dma_slot ? head_wdata : cpu_wdata;
    ram_we    = rst_n && (dma_slot ? head_we :
                          cpu_ram_cs && cpu_io_op == IO_OP_WRITE && cpu_mc == MC_C2);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      claim_q   <= 1'b1;
      rd_pend_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      claim_q   <= claim_d;
      rd_pend_q <= rd_pend_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
endmodule

// File: tb/tb_ram_dma_arbiter.sv
// tb_ram_dma_arbiter: random CPU/DMA traffic against a queue-and-memory reference model
module tb_ram_dma_arbiter;
  localparam int AW = 15, DW = 8, N = 3000, R = 1500;
  typedef struct packed {logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata;} req_t;
  logic clk = 0, rst_n = 0;
  logic [1:0] cpu_io_op = 0;
  logic [2:0] cpu_mc = 0;
  logic cpu_ram_cs = 0, dma_req_valid = 0, dma_we = 0;
  logic [AW-1:0] cpu_addr = 0, dma_addr = 0;
  logic [DW-1:0] cpu_wdata = 0, dma_wdata = 0;
  logic dma_req_ready, dma_rvalid, dma_busy, ram_we;
  logic [DW-1:0] dma_rdata, ram_wdata;
  logic [DW-1:0] ram_rdata = 0;
  logic [AW-1:0] ram_addr;
  always #20 clk = ~clk;
  ram_dma_arbiter dut (
    .clk(clk), .rst_n(rst_n), .cpu_io_op(cpu_io_op), .cpu_mc(cpu_mc),
    .cpu_ram_cs(cpu_ram_cs), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready), .dma_we(dma_we),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_rvalid(dma_rvalid),
    .dma_rdata(dma_rdata), .dma_busy(dma_busy), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );
  logic [DW-1:0] tb_mem [1<<AW] = '{default: 8'hC3};
  always @(posedge clk) begin
    if (ram_we) tb_mem[ram_addr] <= ram_wdata;
    ram_rdata <= tb_mem[ram_addr];
  end
  logic [DW-1:0] mdl_mem [1<<AW] = '{default: 8'hC3};
  req_t mq[$];
  req_t h;
  bit mclaim, s1v, s2v, m_slot, was_full;
  logic [DW-1:0] s1d, exp_rdata;
  logic e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  int n_vec = 0, n_bad = 0;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask
  task automatic mdl_reset();
    mq.delete();
    mclaim = 1;
    s1v = 0;
    s2v = 0;
    exp_rdata = 0;
  endtask
  function automatic logic [AW-1:0] pick_addr();
    return ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 31));
  endfunction
  initial begin
    logic [2:0] seq [4];
    int mc_i;
    seq = '{3'd6, 3'd7, 3'd5, 3'd4};
    mc_i = $urandom_range(0, 3);
    mdl_reset();
    m_slot = 0;
    e_we = 0;
    e_addr = 0;
    e_wdata = 0;
    for (int cyc = 0; cyc < N; cyc++) begin
      @(posedge clk);
      if (rst_n) begin
        was_full = mq.size() >= 4;
        s2v = s1v;
        if (s1v) exp_rdata = s1d;
        s1v = 0;
        if (m_slot) begin
          h = mq.pop_front();
          s1v = !h.we;
          s1d = mdl_mem[h.addr];
        end
        if (e_we) mdl_mem[e_addr] = e_wdata;
        if (cpu_mc == 3'd6) mclaim = cpu_ram_cs && cpu_io_op != 2'b00;
        if (dma_req_valid && !was_full) mq.push_back({dma_we, dma_addr, dma_wdata});
      end
      #1;
      cpu_mc = seq[mc_i % 4];
      mc_i++;
      if ($urandom_range(0, 19) == 0) cpu_mc = 3'($urandom_range(0, 3));
      cpu_io_op = 2'($urandom);
      cpu_ram_cs = $urandom_range(0, 2) != 0;
      cpu_addr = pick_addr();
      cpu_wdata = 8'($urandom);
      dma_req_valid = 1'($urandom);
      dma_we = 1'($urandom);
      dma_addr = pick_addr();
      dma_wdata = 8'($urandom);
      if (cyc >= R - 10 && cyc < R) begin
        cpu_ram_cs = 1;
        cpu_io_op = 2'b10;
        dma_req_valid = 1;
        dma_we = 0;
      end
      if (cyc == R) cpu_mc = 3'd7;
      rst_n = !(cyc < 3 || (cyc >= R && cyc < R + 2));
      if (!rst_n) mdl_reset();
      @(negedge clk);
      m_slot = mq.size() > 0 && (cpu_mc == 3'd4 ||
               (cpu_mc == 3'd6 && !(cpu_ram_cs && cpu_io_op != 2'b00)) ||
               ((cpu_mc == 3'd7 || cpu_mc == 3'd5) && !mclaim));
      if (m_slot) begin
        e_we = mq[0].we;
        e_addr = mq[0].addr;
        e_wdata = mq[0].wdata;
      end else begin
        e_we = rst_n && cpu_ram_cs && cpu_io_op == 2'b01 && cpu_mc == 3'd7;
        e_addr = cpu_addr;
        e_wdata = cpu_wdata;
      end
      chk("ram_we", 32'(ram_we), 32'(e_we));
      chk("ram_addr", 32'(ram_addr), 32'(e_addr));
      chk("ram_wdata", 32'(ram_wdata), 32'(e_wdata));
      chk("dma_req_ready", 32'(dma_req_ready), 32'(mq.size() < 4));
      chk("dma_busy", 32'(dma_busy), 32'(mq.size() > 0 || s1v));
      chk("dma_rvalid", 32'(dma_rvalid), 32'(s2v));
      chk("dma_rdata", 32'(dma_rdata), 32'(exp_rdata));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/ram_dma_arbiter.md
# ram_dma_arbiter

Shares the single-port 32KB main RAM between the M65C02 core and one DMA requester (LCD refresh / block-copy engine). It schedules DMA accesses into RAM slots the CPU provably does not use, derived from the core's IO_Op/MC microcycle signals. The CPU is never stalled (core Wait stays 0). The block sits between the address decoder/CPU bus and the `ram` instance in `soc_top`.

## Interface
- `ADDR_WIDTH`, 15, RAM word-address width (32KB)
- `DATA_WIDTH`, 8, data width
- `FIFO_DEPTH`, 4, DMA request queue entries (power of 2, ≥2)

- `clk` in 1: system clock, 25 MHz
- `rst_n` in 1: reset, asynchronous, active-low
- `cpu_io_op` in 2: core IO_Op (00 none, 01 write, 10 read, 11 fetch)
- `cpu_mc` in 3: core MC microcycle state
- `cpu_ram_cs` in 1: decoder RAM select for `cpu_addr`
- `cpu_addr` in ADDR_WIDTH: CPU address low bits
- `cpu_wdata` in DATA_WIDTH: CPU write data
- `dma_req_valid` in 1: DMA request present
- `dma_req_ready` out 1: request accepted this cycle when valid&ready
- `dma_we` in 1: 1 write, 0 read
- `dma_addr` in ADDR_WIDTH: DMA address
- `dma_wdata` in DATA_WIDTH: DMA write data
- `dma_rvalid` out 1: read data strobe, one clock per read
- `dma_rdata` out DATA_WIDTH: read data
- `dma_busy` out 1: queue non-empty or read in flight
- `ram_we` out 1: RAM write enable
- `ram_addr` out ADDR_WIDTH: RAM address
- `ram_wdata` out DATA_WIDTH: RAM write data
- `ram_rdata` in DATA_WIDTH: RAM registered read data (valid the clock after address)

## Operation
- Microcycle order 6→7→5→4. At MC=6, `cpu_claim = cpu_ram_cs && cpu_io_op != 00`; held in `claim_q` for MC=7,5 of that microcycle.
- DMA slot (`dma_slot`) when queue non-empty and: MC=4; or MC=6 with !cpu_claim; or MC∈{7,5} with !claim_q. Free microcycle → up to 4 DMA accesses; CPU-owned → 1 (MC=4).
- In a DMA slot: `ram_addr/ram_wdata/ram_we` = queue head; head popped. Otherwise `ram_addr=cpu_addr`, `ram_wdata=cpu_wdata`, `ram_we = cpu_ram_cs && cpu_io_op==01 && cpu_mc==7`.
- Queue: in-order FIFO of {we, addr, wdata}; `dma_req_ready = !full`. Push and pop same cycle permitted; when full, no push even if popping.
- Reads: 2-stage pending pipeline; `dma_rdata <= ram_rdata` one clock after a read slot; `dma_rvalid` pulses next cycle. Writes produce no response.
- Ordering: DMA ops in issue order; CPU/DMA same-address order = slot order.
- Unknown MC (0–3): no DMA slot, CPU path only.

## Timing
- Reset (async): queue empty, claim_q=1, pipeline cleared; `dma_req_ready=1`, `dma_rvalid=0`, `dma_rdata=0`, `dma_busy=0`, `ram_we=0`, `ram_addr=cpu_addr`, `ram_wdata=cpu_wdata`. In-flight requests/reads discarded, no rvalid after deassert.
- Accept→slot: min 1 clock (accept t, earliest slot t+1); max 4 clocks wait for head.
- Read slot t → `dma_rvalid` at t+2.
- `ram_*` outputs combinational from MC/queue head; all other outputs registered.

## Structure
- Shared package/include `soc_bus_pkg`: IO_OP_NONE/WRITE/READ/FETCH, MC_C1=6, MC_C2=7, MC_C3=5, MC_C4=4.
- Sub-module `dma_req_fifo` (sync FIFO, full/empty, async active-low reset); arbiter holds slot logic and read pipeline.

## Test plan
- Reset mid-burst: 3 queued reads, rst_n low at MC=7 → empty, rvalid never pulses, ready=1.
- CPU reads $0123 every microcycle, DMA writes $55→$0200 → ram_we with $0200 only at MC=4; CPU reads $0123 unaffected.
- CPU io_op=00 full microcycle, 4 queued DMA reads $10–$13 → 4 consecutive slots MC 6,7,5,4; rvalid 4 clocks, data in order.
- CPU write $AA→$0010 at MC=7 with DMA write pending → ram_we MC=7 CPU, MC=4 DMA.
- Fill 4 entries while CPU-owned → ready=0; pop at MC=4 → ready=1 next clock; no entry lost.
- CPU writes UART (cpu_ram_cs=0, io_op=01) → microcycle free, no CPU ram_we.
